// File: rtl/proc_hier_pkg.sv
// Shared definitions for the processor-hierarchy statistics shell: default widths,
// the counter ceiling and the trace record layout also used by core-side tooling.
package proc_hier_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_DATA_W = 16;

  localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

  // Field order is shared with offline trace decoders; append, never reorder.
  typedef struct packed {
    logic                  valid;
    logic                  regValid;
    logic                  loadValid;
    logic                  storeValid;
    logic [2:0]            regNum;
    logic [DEF_DATA_W-1:0] regData;
    logic [DEF_DATA_W-1:0] addr;
    logic [DEF_DATA_W-1:0] memData;
  } trace_t;

endpackage

// File: rtl/proc_hier_stats_if.sv
// Core-to-statistics event bundle: commit, memory and cache strobes from the pipelined core.
interface proc_hier_stats_if
  import proc_hier_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    // Strobe semantics: no valid/ready pair and no backpressure. Every signal is
    // sampled on each rising clock edge; a strobe high at an edge is exactly one
    // event, and the observer can never stall the core.
    logic              halt;
    logic              reg_write;
    logic [2:0]        write_register;
    logic [DATA_W-1:0] write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              icache_req;
    logic              icache_hit;
    logic              dcache_req;
    logic              dcache_hit;

    modport master (
        output halt, reg_write, write_register, write_data,
        output mem_read, mem_write, mem_address, mem_data_in, mem_data_out,
        output icache_req, icache_hit, dcache_req, dcache_hit
    );

    modport slave (
        input halt, reg_write, write_register, write_data,
        input mem_read, mem_write, mem_address, mem_data_in, mem_data_out,
        input icache_req, icache_hit, dcache_req, dcache_hit
    );

endinterface

// File: rtl/proc_hier_stats_sat_counter.sv
// Saturating event counter with synchronous clear and a freeze input that holds the value.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic         freeze,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en && !freeze && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/proc_hier_stats.sv
// Processor-hierarchy statistics and halt shell: cycle/instruction/cache counters,
// sticky halt and protocol-error flags. Optional trace port under PROC_HIER_TRACE_EN.
module proc_hier_stats
  import proc_hier_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    proc_hier_stats_if.slave    core,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    inst_count,
    output logic [CNT_W-1:0]    icache_req_count,
    output logic [CNT_W-1:0]    icache_hit_count,
    output logic [CNT_W-1:0]    dcache_req_count,
    output logic [CNT_W-1:0]    dcache_hit_count,
    output logic                halted,
    output logic                err
`ifdef PROC_HIER_TRACE_EN
    ,
    output logic                trace_valid,
    output logic                trace_reg_valid,
    output logic                trace_load_valid,
    output logic                trace_store_valid,
    output logic [2:0]          trace_reg,
    output logic [DATA_W-1:0]   trace_reg_data,
    output logic [DATA_W-1:0]   trace_addr,
    output logic [DATA_W-1:0]   trace_mem_data
`endif
);

    logic instEvent;
    logic protoErr;

    // Halt, a register write and a store each retire one instruction; OR keeps it single.
    assign instEvent = core.halt | core.reg_write | core.mem_write;
    assign protoErr  = (core.mem_read & core.mem_write)
                     | (core.icache_hit & ~core.icache_req)
                     | (core.dcache_hit & ~core.dcache_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
            err    <= 1'b0;
        end else if (!halted) begin
            if (core.halt) halted <= 1'b1;
            if (protoErr)  err    <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) uCycleCnt (
        .clk(clk), .clear(rst), .en(1'b1), .freeze(halted), .count(cycle_count)
    );

    sat_counter #(.W(CNT_W)) uInstCnt (
        .clk(clk), .clear(rst), .en(instEvent), .freeze(halted), .count(inst_count)
    );

    sat_counter #(.W(CNT_W)) uIcacheReqCnt (
        .clk(clk), .clear(rst), .en(core.icache_req), .freeze(halted), .count(icache_req_count)
    );

    sat_counter #(.W(CNT_W)) uIcacheHitCnt (
        .clk(clk), .clear(rst), .en(core.icache_hit), .freeze(halted), .count(icache_hit_count)
    );

    sat_counter #(.W(CNT_W)) uDcacheReqCnt (
        .clk(clk), .clear(rst), .en(core.dcache_req), .freeze(halted), .count(dcache_req_count)
    );

    sat_counter #(.W(CNT_W)) uDcacheHitCnt (
        .clk(clk), .clear(rst), .en(core.dcache_hit), .freeze(halted), .count(dcache_hit_count)
    );

`ifdef PROC_HIER_TRACE_EN
    trace_t traceNext;
    trace_t traceQ;

    // A store wins over a simultaneous load; that collision also raises err above.
    always_comb begin
        traceNext            = '0;
        traceNext.valid      = core.reg_write | core.mem_read | core.mem_write;
        traceNext.regValid   = core.reg_write;
        traceNext.loadValid  = core.mem_read & ~core.mem_write;
        traceNext.storeValid = core.mem_write;
        if (core.reg_write) begin
            traceNext.regNum  = core.write_register;
            traceNext.regData = core.write_data;
        end
        if (core.mem_write) begin
            traceNext.addr    = core.mem_address;
            traceNext.memData = core.mem_data_in;
        end else if (core.mem_read) begin
            traceNext.addr    = core.mem_address;
            traceNext.memData = core.mem_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || halted) begin
            traceQ <= '0;
        end else begin
            traceQ <= traceNext;
        end
    end

    assign trace_valid       = traceQ.valid;
    assign trace_reg_valid   = traceQ.regValid;
    assign trace_load_valid  = traceQ.loadValid;
    assign trace_store_valid = traceQ.storeValid;
    assign trace_reg         = traceQ.regNum;
    assign trace_reg_data    = traceQ.regData;
    assign trace_addr        = traceQ.addr;
    assign trace_mem_data    = traceQ.memData;
`else
    logic unusedTraceBits;
    assign unusedTraceBits = ^{core.write_register, core.write_data, core.mem_address,
                               core.mem_data_in, core.mem_data_out};
`endif

endmodule

// File: tb/tb_proc_hier_stats.sv
// Self-checking bench for proc_hier_stats; trace checks compile in with PROC_HIER_TRACE_EN.
module tb_proc_hier_stats;
  import proc_hier_pkg::*;

  localparam int W  = 32;
  localparam int DW = 16;

  logic clk;
  logic rst;
  logic [W-1:0] cycle_count, inst_count;
  logic [W-1:0] icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count;
  logic halted, err;
`ifdef PROC_HIER_TRACE_EN
  logic trace_valid, trace_reg_valid, trace_load_valid, trace_store_valid;
  logic [2:0] trace_reg;
  logic [DW-1:0] trace_reg_data, trace_addr, trace_mem_data;
`endif

  proc_hier_stats_if #(.DATA_W(DW)) core_if ();

  proc_hier_stats #(.CNT_W(W), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .core(core_if.slave),
    .cycle_count(cycle_count),
    .inst_count(inst_count),
    .icache_req_count(icache_req_count),
    .icache_hit_count(icache_hit_count),
    .dcache_req_count(dcache_req_count),
    .dcache_hit_count(dcache_hit_count),
    .halted(halted),
    .err(err)
`ifdef PROC_HIER_TRACE_EN
    ,
    .trace_valid(trace_valid),
    .trace_reg_valid(trace_reg_valid),
    .trace_load_valid(trace_load_valid),
    .trace_store_valid(trace_store_valid),
    .trace_reg(trace_reg),
    .trace_reg_data(trace_reg_data),
    .trace_addr(trace_addr),
    .trace_mem_data(trace_mem_data)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  logic [W-1:0] m_cyc, m_inst, m_ir, m_ih, m_dr, m_dh;
  logic m_halted, m_err;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + 1;
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = '0; m_inst = '0; m_ir = '0; m_ih = '0; m_dr = '0; m_dh = '0;
    m_halted = 1'b0; m_err = 1'b0;
  endtask

  task automatic clear_inputs();
    core_if.halt = 0; core_if.reg_write = 0; core_if.write_register = '0;
    core_if.write_data = '0; core_if.mem_read = 0; core_if.mem_write = 0;
    core_if.mem_address = '0; core_if.mem_data_in = '0; core_if.mem_data_out = '0;
    core_if.icache_req = 0; core_if.icache_hit = 0;
    core_if.dcache_req = 0; core_if.dcache_hit = 0;
  endtask

  // driver: one clock of core events, entered and left on a falling edge
  task automatic step(input logic h, input logic rw, input logic mw, input logic mr,
                      input logic ir, input logic ih, input logic dr, input logic dh);
    core_if.halt = h; core_if.reg_write = rw; core_if.mem_write = mw; core_if.mem_read = mr;
    core_if.icache_req = ir; core_if.icache_hit = ih;
    core_if.dcache_req = dr; core_if.dcache_hit = dh;
    @(posedge clk);
    if (!m_halted) begin
      m_cyc = sat_inc(m_cyc);
      if (h | rw | mw) m_inst = sat_inc(m_inst);
      if (ir) m_ir = sat_inc(m_ir);
      if (ih) m_ih = sat_inc(m_ih);
      if (dr) m_dr = sat_inc(m_dr);
      if (dh) m_dh = sat_inc(m_dh);
      if ((mr & mw) | (ih & ~ir) | (dh & ~dr)) m_err = 1'b1;
      if (h) m_halted = 1'b1;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_expected();
    exp_q.push_back(m_cyc);
    exp_q.push_back(m_inst);
    exp_q.push_back(m_ir);
    exp_q.push_back(m_ih);
    exp_q.push_back(m_dr);
    exp_q.push_back(m_dh);
    exp_q.push_back({{(W-1){1'b0}}, m_halted});
    exp_q.push_back({{(W-1){1'b0}}, m_err});
  endtask

  task automatic compare_outputs(input string tag);
    if (exp_q.size() < 8) begin
      n_vec++; n_err++;
      $display("FAIL %s.queue: got %0d entries expected 8", tag, exp_q.size());
    end else begin
      check_val({tag, ".cycle"},   cycle_count,      exp_q.pop_front());
      check_val({tag, ".inst"},    inst_count,       exp_q.pop_front());
      check_val({tag, ".ireq"},    icache_req_count, exp_q.pop_front());
      check_val({tag, ".ihit"},    icache_hit_count, exp_q.pop_front());
      check_val({tag, ".dreq"},    dcache_req_count, exp_q.pop_front());
      check_val({tag, ".dhit"},    dcache_hit_count, exp_q.pop_front());
      check_val({tag, ".halted"},  {{(W-1){1'b0}}, halted}, exp_q.pop_front());
      check_val({tag, ".err"},     {{(W-1){1'b0}}, err},    exp_q.pop_front());
    end
  endtask

  task automatic score(input string tag);
    push_expected();
    compare_outputs(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();
    score("reset");

    // idle run then halt: the halt cycle counts in both cycle and instruction totals
    idle(10);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_val("halt.cycle_lit", cycle_count, 32'd11);
    check_val("halt.inst_lit", inst_count, 32'd1);
    score("halt");
    step(0, 1, 1, 0, 1, 1, 1, 1);
    idle(4);
    score("frozen");

    // instruction counting with overlapping retire sources
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check_val("inst7.lit", inst_count, 32'd7);
    score("inst7");

    // cache events, all legal
    do_reset();
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 0, 1, (i < 6), (i < 3), (i == 0));
    check_val("cache.ireq_lit", icache_req_count, 32'd8);
    check_val("cache.ihit_lit", icache_hit_count, 32'd6);
    check_val("cache.dreq_lit", dcache_req_count, 32'd3);
    check_val("cache.dhit_lit", dcache_hit_count, 32'd1);
    score("cache");

    // random legal traffic
    for (int i = 0; i < 40; i++) begin
      logic ir, dr, mr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      step(0, 1'($urandom_range(0, 1)), ~mr & 1'($urandom_range(0, 1)), mr,
           ir, ir & 1'($urandom_range(0, 1)), dr, dr & 1'($urandom_range(0, 1)));
    end
    score("random");

    // read+write collision sets sticky err, counting continues
    step(0, 0, 1, 1, 0, 0, 0, 0);
    idle(3);
    check_val("rw_err.lit", {{(W-1){1'b0}}, err}, 32'd1);
    score("rw_err");

    // hit without request on each cache
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    score("ihit_err");
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    score("dhit_err");

    // saturation of the cycle counter
    do_reset();
    idle(2);
    force dut.uCycleCnt.count = 32'hFFFF_FFFE;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    release dut.uCycleCnt.count;
    m_cyc = 32'hFFFF_FFFE;
    idle(3);
    check_val("sat.lit", cycle_count, 32'hFFFF_FFFF);
    score("sat");

    // reset pulse after halt restarts everything
    step(1, 0, 0, 0, 1, 1, 0, 0);
    idle(2);
    do_reset();
    score("rst_mid");
    idle(4);
    step(0, 1, 0, 0, 1, 0, 0, 0);
    score("resume");

`ifdef PROC_HIER_TRACE_EN
    core_if.mem_address = 16'h0040;
    core_if.mem_data_in = 16'h1234;
    step(0, 0, 1, 0, 0, 0, 0, 0);
    check_val("trace.store_valid", {31'd0, trace_store_valid}, 32'd1);
    check_val("trace.valid", {31'd0, trace_valid}, 32'd1);
    check_val("trace.addr", {16'd0, trace_addr}, 32'h0040);
    check_val("trace.data", {16'd0, trace_mem_data}, 32'h1234);
    core_if.mem_address = 16'h0022;
    core_if.mem_data_out = 16'hBEEF;
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check_val("trace.load_valid", {31'd0, trace_load_valid}, 32'd1);
    check_val("trace.load_data", {16'd0, trace_mem_data}, 32'hBEEF);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check_val("trace.halted_zero", {31'd0, trace_valid}, 32'd0);
    score("trace");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_hier_stats.md
Name: proc_hier_stats

Overview:
- Processor-hierarchy statistics and halt shell.
- Sits beside the pipelined core inside the processor hierarchy and takes the core's per-cycle commit and cache-event strobes.
- Keeps the cycle, instruction and cache counters, latches halt, and flags illegal memory-strobe combinations.
- All counters freeze once the core halts, so the final statistics stay readable.

Parameters:
- CNT_W, 32: width of every counter output.
- DATA_W, 16: width of PC, instruction, address and data buses.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- halt  in  1  core Halt in memory/writeback stage this cycle.
- reg_write  in  1  register-file write this cycle.
- write_register  in  3  destination register.
- write_data  in  DATA_W  register write data.
- mem_read  in  1  data-memory read this cycle.
- mem_write  in  1  data-memory write this cycle.
- mem_address  in  DATA_W  data-memory address.
- mem_data_in  in  DATA_W  store data.
- mem_data_out  in  DATA_W  load data.
- icache_req, icache_hit, dcache_req, dcache_hit  in  1 each  cache event strobes.
- cycle_count  out  CNT_W  cycles since reset release.
- inst_count  out  CNT_W  committed instructions.
- icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count  out  CNT_W each  event totals.
- halted  out  1  sticky halt flag.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: while rst=1 at a rising edge, all counters, halted and err go to 0. Reset mid-run restarts everything from zero.
- Active cycle means rst=0 and halted=0. Inputs are ignored when the cycle is not active.
- Each active cycle, counters increment as follows:
  - cycle_count += 1, unconditionally.
  - inst_count += 1 if (halt | reg_write | mem_write). The increment is exactly once even when several of these are high together.
  - Each cache counter += 1 when its strobe is high.
- Latency: all outputs are registered. An event sampled at edge N is visible after edge N.
- Halt cycle: the cycle in which halt=1 is itself counted, in both cycle_count and inst_count. halted=1 after that edge.
- After halt: all counters freeze until rst. Further halt or strobes have no effect.
- Saturation: every counter saturates at 2^CNT_W-1 and never wraps.
- err is set (sticky until rst) on any active cycle with either:
  - mem_read & mem_write, or
  - icache_hit & ~icache_req, or
  - dcache_hit & ~dcache_req.
- Counting still proceeds normally on an error cycle.
- write_register, write_data, mem_address, mem_data_in and mem_data_out are used only by the optional trace port.

Optional Feature:
- Macro: PROC_HIER_TRACE_EN.
- When defined, the block adds registered trace outputs, updated on active cycles:
  - trace_valid (1): reg_write|mem_read|mem_write.
  - trace_reg_valid, trace_load_valid, trace_store_valid (1 each).
  - trace_reg (3), trace_reg_data (DATA_W).
  - trace_addr (DATA_W), trace_mem_data (DATA_W).
- trace_mem_data carries mem_data_out for a load and mem_data_in for a store. If both are high, the store takes priority and err is also set.
- All trace outputs are 0 in reset and after halt.
- When the macro is undefined, these ports and registers do not exist.

Decomposition:
- Shared package proc_hier_pkg holds:
  - CNT_W and DATA_W defaults.
  - CNT_MAX constant.
  - Trace record struct, so the same layout is used by core-side tooling.
- One natural sub-module, sat_counter: enable plus freeze input, synchronous clear, saturating increment. It is instantiated six times.

Test Plan:
- Reset release, 10 idle cycles, then halt=1 for one cycle. Required: cycle_count=11, inst_count=1, halted=1. Counters unchanged 5 cycles later.
- 4 cycles of reg_write=1 and 2 cycles of mem_write=1, then halt with reg_write=1 in the same cycle. Required: inst_count=7.
- icache_req=1 for 8 cycles with icache_hit=1 on 6 of them; dcache_req=3, dcache_hit=1. Required: counts 8/6/3/1, err=0.
- mem_read=1 and mem_write=1 together in one cycle. Required: err=1, held until rst.
- Preload cycle_count to 0xFFFFFFFE via force, run 3 cycles. Required: 0xFFFFFFFF held, no wrap.
- Pulse rst mid-run after halt. Required: all outputs 0, counting resumes. With PROC_HIER_TRACE_EN, a store to 0x0040 of 0x1234 yields trace_store_valid=1, trace_addr=0x0040, trace_mem_data=0x1234.
